stream_inverter_stage: RTL and testbench
========================================

// Module: stream_inverter_stage
// PURPOSE
//  - Registered valid/ready stream stage that conditionally inverts each beat before it goes downstream.
//  - Each data bit is inverted by a mux-based NOT cell: sel=data bit, d0=1, d1=0.
//    A per-beat 'inv' flag picks inverted or original data.
//  - Placed between a producer and the next consumer. Holds a 2-entry skid, so
//    full throughput is kept while up_ready is registered.
// PARAMETERS
//  WIDTH      8    data width in bits (>=1)
//  CNT_W      16   width of the accepted-beat counter
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst_n      in   1       synchronous reset, active-low
//  up_valid   in   1       upstream beat valid
//  up_ready   out  1       stage can accept a beat (registered)
//  up_data    in   WIDTH   upstream data
//  up_inv     in   1       1: invert this beat; 0: pass it unchanged
//  down_valid out  1       downstream beat valid (registered)
//  down_ready in   1       downstream accepts
//  down_data  out  WIDTH   processed data (registered)
//  beat_cnt   out  CNT_W   count of beats accepted downstream
// BEHAVIOUR
//  - Reset: synchronous, active-low. While rst_n=0 at posedge:
//    down_valid=0, down_data=0, up_ready=0, beat_cnt=0, skid empty.
//    up_ready becomes 1 on the first posedge after rst_n=1.
//  - Upstream transfer: up_valid&&up_ready at posedge. Downstream transfer: down_valid&&down_ready at posedge.
//  - Transform: f(d,inv) = inv ? ~d : d, bitwise, computed combinationally on
//    up_data before capture. Nothing is computed on the output side.
//  - Latency: a beat accepted at edge N is shown on down_data/down_valid after edge N,
//    when the output register is empty or draining at edge N.
//  - Two storage slots: OUT (drives down_*) and SKID.
//    States: EMPTY (none valid), ONE (OUT valid), FULL (OUT+SKID valid).
//    EMPTY --up xfer--> ONE.
//    ONE   --up xfer, no down xfer--> FULL (beat goes to SKID).
//    ONE   --up xfer & down xfer--> ONE (OUT reloaded from input).
//    ONE   --down xfer only--> EMPTY.
//    FULL  --down xfer--> ONE (SKID moves to OUT). up_ready is 0 in FULL.
//  - up_ready = registered (next_state != FULL). Never combinational from down_ready.
//  - Order is preserved. No beat is dropped or duplicated.
//  - Back-pressure: while down_valid=1 and down_ready=0, down_data and down_valid hold stable.
//  - up_data/up_inv are ignored when up_valid=0 or up_ready=0.
//  - beat_cnt increments by 1 on each downstream transfer and wraps from 2^CNT_W-1 to 0.
//  - Reset mid-stream: both slots are discarded and the count clears. A beat on
//    down_* in the reset cycle is not counted.
//  - X on up_data while up_valid=0 must not reach down_data.
// STRUCTURE
//  - Package stream_inverter_pkg holds:
//    typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;
//    localparam DEFAULT_WIDTH=8; localparam DEFAULT_CNT_W=16.
//  - Sub-module bitwise_mux_not #(WIDTH): a generate loop of mux-based NOT cells
//    giving ~d, then a final mux on inv selects ~d or d.
//  - Skid control FSM and beat counter stay in the top module.
// TESTING
//  - Reset: hold rst_n=0 for 3 cycles with up_valid=1.
//    -> down_valid=0, up_ready=0, beat_cnt=0. up_ready=1 one edge after release.
//  - Passthrough/invert: send 8'hA5 inv=1, then 8'h3C inv=0, down_ready=1.
//    -> down_data 8'h5A, then 8'h3C, each 1 cycle after acceptance.
//  - Full throughput: 100 back-to-back beats with down_ready=1.
//    -> one beat per cycle, no bubbles, beat_cnt=100.
//  - Back-pressure: down_ready=0 while sending 3 beats.
//    -> 2 accepted, up_ready=0, down_data held stable. Release -> order kept, third beat then accepted.
//  - Wrap: CNT_W=4, send 17 beats. -> beat_cnt ends at 1.
//  - Mid-stream reset in state FULL. -> both slots discarded, beat_cnt=0. Next beat after release comes out correctly.

Source files
------------

// File: rtl/stream_inverter_pkg.sv
// stream_inverter_pkg: shared skid-state encoding and default widths for the inverter stage
package stream_inverter_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 16;
endpackage

// File: rtl/stream_inverter_stage_if.sv
// stream_inverter_stage_if: upstream and downstream valid/ready handshake of the inverter stage
interface stream_inverter_stage_if import stream_inverter_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] up_data;
  logic             up_inv;
  logic             down_valid;
  logic             down_ready;
  logic [WIDTH-1:0] down_data;
  modport master (
    output up_valid, up_data, up_inv, down_ready,
    input  up_ready, down_valid, down_data
  );
  modport slave (
    input  up_valid, up_data, up_inv, down_ready,
    output up_ready, down_valid, down_data
  );
endinterface

// File: rtl/stream_inverter_stage_bitwise_mux_not.sv
// bitwise_mux_not: per-bit mux NOT cells (sel=d, d0=1, d1=0), then inv selects ~d or d
module bitwise_mux_not #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d_i,
  input  logic             inv_i,
  output logic [WIDTH-1:0] y_o
);
  logic [WIDTH-1:0] nd;
  for (genvar i = 0; i < WIDTH; i++) begin : g_not
    assign nd[i] = d_i[i] ? 1'b0 : 1'b1;
  end
  assign y_o = inv_i ? nd : d_i;
endmodule

// File: rtl/stream_inverter_stage.sv
// stream_inverter_stage: registered valid/ready stage with 2-entry skid that optionally inverts each beat
module stream_inverter_stage import stream_inverter_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_inverter_stage_if.slave s,
  output logic [CNT_W-1:0] beat_cnt
);
  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d, skid_q, skid_d, f_data;
  logic             up_ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic             up_xfer, down_xfer;

  bitwise_mux_not #(.WIDTH(WIDTH)) u_not (
    .d_i   (s.up_data),
    .inv_i (s.up_inv),
    .y_o   (f_data)
  );

  assign up_xfer      = s.up_valid && up_ready_q;
  assign down_xfer    = (state_q != EMPTY) && s.down_ready;
  assign s.up_ready   = up_ready_q;
  assign s.down_valid = state_q != EMPTY;
  assign s.down_data  = out_q;
  assign beat_cnt     = cnt_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (up_xfer) begin
        state_d = ONE;
        out_d   = f_data;
      end
      ONE: begin
        if (up_xfer && !down_xfer) begin
          state_d = FULL;
          skid_d  = f_data;
        end else if (up_xfer) out_d = f_data;
        else if (down_xfer) state_d = EMPTY;
      end
      FULL: if (down_xfer) begin
        state_d = ONE;
        out_d   = skid_q;
      end
      default: state_d = EMPTY;
    endcase
  end

  // up_ready looks ahead at the next state so it never depends combinationally on down_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      up_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      up_ready_q <= state_d != FULL;
      cnt_q      <= cnt_q + CNT_W'(down_xfer);
    end
  end
endmodule

// File: tb/tb_stream_inverter_stage.sv
// tb_stream_inverter_stage: scoreboard bench with directed and random traffic against a queue reference model
module tb_stream_inverter_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;
  int n_vec = 0;
  int n_bad = 0;
  int model_cnt = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always #5 clk = ~clk;

  stream_inverter_stage_if #(.WIDTH(8)) bus ();
  stream_inverter_stage_if #(.WIDTH(8)) bus4 ();

  assign bus4.up_valid   = bus.up_valid;
  assign bus4.up_data    = bus.up_data;
  assign bus4.up_inv     = bus.up_inv;
  assign bus4.down_ready = bus.down_ready;

  stream_inverter_stage #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .s(bus.slave), .beat_cnt(cnt16)
  );
  stream_inverter_stage #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .s(bus4.slave), .beat_cnt(cnt4)
  );

  function automatic logic [7:0] ref_f(input logic [7:0] d, input logic inv);
    return inv ? (8'hFF - d) : d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic inv);
    logic acc;
    bus.up_valid = 1'b1;
    bus.up_data  = d;
    bus.up_inv   = inv;
    for (int k = 0; k < 50; k++) begin
      acc = bus.up_ready;
      cyc();
      if (acc) return;
    end
    n_vec++;
    n_bad++;
    $display("FAIL send_timeout: got up_ready=0 for 50 cycles expected acceptance");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.up_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic drain();
    bus.up_valid = 1'b0;
    bus.down_ready = 1'b1;
    repeat (4) cyc();
  endtask

  // Monitor: transfers are judged at negedge, where inputs and outputs are settled for the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.down_valid), 32'd1);
        chk("hold_data", 32'(bus.down_data), 32'(prev_data));
      end
      if (bus.down_valid && bus.down_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL sb_extra: got beat %0h expected none", bus.down_data);
        end else chk("sb_data", 32'(bus.down_data), 32'(exp_q.pop_front()));
        model_cnt++;
      end
      if (bus.up_valid && bus.up_ready) exp_q.push_back(ref_f(bus.up_data, bus.up_inv));
      prev_stall = bus.down_valid && !bus.down_ready;
      prev_data  = bus.down_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b0, b1, b2, held;
    bus.up_valid = 1'b1;
    bus.up_data = 8'h77;
    bus.up_inv = 1'b1;
    bus.down_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_down_valid", 32'(bus.down_valid), 32'd0);
    chk("rst_up_ready", 32'(bus.up_ready), 32'd0);
    chk("rst_beat_cnt", 32'(cnt16), 32'd0);
    chk("rst_down_data", 32'(bus.down_data), 32'd0);
    rst_n = 1'b1;
    bus.up_valid = 1'b0;
    cyc();
    chk("rel_up_ready", 32'(bus.up_ready), 32'd1);

    bus.up_valid = 1'b1;
    bus.up_data = 8'hA5;
    bus.up_inv = 1'b1;
    cyc();
    chk("inv_valid", 32'(bus.down_valid), 32'd1);
    chk("inv_data", 32'(bus.down_data), 32'h5A);
    bus.up_data = 8'h3C;
    bus.up_inv = 1'b0;
    cyc();
    chk("pass_data", 32'(bus.down_data), 32'h3C);
    drain();
    chk("dir_cnt", 32'(cnt16), 32'd2);

    do_reset();
    bus.down_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      chk("tp_up_ready", 32'(bus.up_ready), 32'd1);
      bus.up_valid = 1'b1;
      bus.up_data = 8'($urandom);
      bus.up_inv = 1'($urandom);
      cyc();
      chk("tp_down_valid", 32'(bus.down_valid), 32'd1);
    end
    bus.up_valid = 1'b0;
    cyc();
    chk("tp_cnt", 32'(cnt16), 32'd100);
    chk("tp_cnt4", 32'(cnt4), 32'd4);

    do_reset();
    bus.down_ready = 1'b0;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    send(b0, 1'b1);
    send(b1, 1'b0);
    chk("bp_up_ready", 32'(bus.up_ready), 32'd0);
    held = ref_f(b0, 1'b1);
    bus.up_valid = 1'b1;
    bus.up_data = b2;
    bus.up_inv = 1'b1;
    repeat (3) begin
      cyc();
      chk("bp_held", 32'(bus.down_data), 32'(held));
      chk("bp_stall", 32'(bus.up_ready), 32'd0);
    end
    bus.down_ready = 1'b1;
    send(b2, 1'b1);
    drain();
    chk("bp_cnt", 32'(cnt16), 32'd3);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    do_reset();
    for (int i = 0; i < 17; i++) send(8'($urandom), 1'($urandom));
    drain();
    chk("wrap_cnt4", 32'(cnt4), 32'd1);
    chk("wrap_cnt16", 32'(cnt16), 32'd17);

    do_reset();
    bus.down_ready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    chk("mr_full", 32'(bus.up_ready), 32'd0);
    bus.up_valid = 1'b0;
    bus.down_ready = 1'b1;
    rst_n = 1'b0;
    cyc();
    chk("mr_down_valid", 32'(bus.down_valid), 32'd0);
    chk("mr_cnt", 32'(cnt16), 32'd0);
    rst_n = 1'b1;
    cyc();
    send(8'hC3, 1'b1);
    bus.up_valid = 1'b0;
    chk("mr_data", 32'(bus.down_data), 32'h3C);
    drain();
    chk("mr_cnt_after", 32'(cnt16), 32'd1);

    do_reset();
    for (int i = 0; i < 300; i++) begin
      bus.up_valid = 1'($urandom);
      bus.up_data = 8'($urandom);
      bus.up_inv = 1'($urandom);
      bus.down_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    drain();
    chk("rnd_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("rnd_cnt16", 32'(cnt16), 32'(model_cnt % 65536));
    chk("rnd_cnt4", 32'(cnt4), 32'(model_cnt % 16));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
